bu_writeback: RTL and testbench

BU_WRITEBACK -- requirements
Module: bu_writeback

---
 rtl/ntt_pkg.sv | 20 ++
 rtl/bu_wb_addr_gen.sv | 49 ++++
 rtl/bu_writeback.sv | 160 ++++++++++++++++
 tb/tb_bu_writeback.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT constants, writeback FSM states and layer-length check
package ntt_pkg;
   localparam int DATA_WIDTH      = 12;
   localparam int ADDR_WIDTH      = 5;
   localparam int N_BU            = 8;
   localparam int N_BANK          = 8;
   localparam int BEATS_PER_LAYER = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } wb_state_e;

   // Legal butterfly distances are the powers of two from 2 to 128.
   function automatic logic len_is_legal(input logic [7:0] len);
      return (len >= 8'd2) && ((len & (len - 8'd1)) == 8'd0);
   endfunction
endpackage

// File: rtl/bu_wb_addr_gen.sv
// rtl/bu_wb_addr_gen.sv - maps each BU's upper/lower output of group g to bank, row and port
module bu_wb_addr_gen #(
   parameter int ADDR_WIDTH = ntt_pkg::ADDR_WIDTH
) (
   input  logic [7:0]                          len_i,
   input  logic [3:0]                          g_i,
   output logic [3*ntt_pkg::N_BU-1:0]          bank_a_o,
   output logic [ADDR_WIDTH*ntt_pkg::N_BU-1:0] addr_a_o,
   output logic [ntt_pkg::N_BU-1:0]            port_a_o,
   output logic [3*ntt_pkg::N_BU-1:0]          bank_b_o,
   output logic [ADDR_WIDTH*ntt_pkg::N_BU-1:0] addr_b_o,
   output logic [ntt_pkg::N_BU-1:0]            port_b_o
);
   import ntt_pkg::*;

   logic [7:0] mask;
   logic [7:0] t;
   logic [7:0] i_lo;
   logic [7:0] i_hi;
   logic       wide;

   // len is a power of two, so t div len / t mod len reduce to masking; the
   // coefficient index is the high part shifted up one place plus the offset.
   always_comb begin
      bank_a_o = '0;
      addr_a_o = '0;
      port_a_o = '0;
      bank_b_o = '0;
      addr_b_o = '0;
      port_b_o = '0;
      mask     = len_i - 8'd1;
      wide     = (len_i >= 8'd8);
      t        = '0;
      i_lo     = '0;
      i_hi     = '0;
      for (int k = 0; k < N_BU; k++) begin
         t    = {1'b0, g_i, 3'(k)};
         i_lo = ((t & ~mask) << 1) | (t & mask);
         i_hi = i_lo + len_i;
         bank_a_o[3*k +: 3]                   = i_lo[2:0];
         addr_a_o[ADDR_WIDTH*k +: ADDR_WIDTH] = ADDR_WIDTH'(i_lo[7:3]);
         bank_b_o[3*k +: 3]                   = i_hi[2:0];
         addr_b_o[ADDR_WIDTH*k +: ADDR_WIDTH] = ADDR_WIDTH'(i_hi[7:3]);
         // Short layers pack 16 coefficients into rows 2g (port A) and 2g+1 (port B).
         port_a_o[k] = wide ? 1'b0 : i_lo[3];
         port_b_o[k] = wide ? 1'b1 : i_hi[3];
      end
   end
endmodule

// File: rtl/bu_writeback.sv
// rtl/bu_writeback.sv - writes eight butterfly-unit result pairs per beat into eight dual-port banks
module bu_writeback #(
   parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = ntt_pkg::ADDR_WIDTH
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   start_i,
   input  logic [7:0]                             len_i,
   input  logic                                   valid_i,
   input  logic [ntt_pkg::N_BU*DATA_WIDTH-1:0]    bu_a_i,
   input  logic [ntt_pkg::N_BU*DATA_WIDTH-1:0]    bu_b_i,
   output logic [ntt_pkg::N_BANK-1:0]             we_a_o,
   output logic [ntt_pkg::N_BANK-1:0]             we_b_o,
   output logic [ntt_pkg::N_BANK*ADDR_WIDTH-1:0]  addr_a_o,
   output logic [ntt_pkg::N_BANK*ADDR_WIDTH-1:0]  addr_b_o,
   output logic [ntt_pkg::N_BANK*DATA_WIDTH-1:0]  din_a_o,
   output logic [ntt_pkg::N_BANK*DATA_WIDTH-1:0]  din_b_o,
   output logic                                   busy_o,
   output logic                                   done_o,
   output logic                                   err_o
);
   import ntt_pkg::*;

   wb_state_e                      state_q, state_d;
   logic [3:0]                     g_q, g_d;
   logic [7:0]                     len_q, len_d;
   logic                           err_q, err_d;
   logic [N_BANK-1:0]              we_a_q, we_a_d, we_b_q, we_b_d;
   logic [N_BANK*ADDR_WIDTH-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
   logic [N_BANK*DATA_WIDTH-1:0]   din_a_q, din_a_d, din_b_q, din_b_d;
   logic                           beat;

   logic [3*N_BU-1:0]              bank_a, bank_b;
   logic [ADDR_WIDTH*N_BU-1:0]     gen_addr_a, gen_addr_b;
   logic [N_BU-1:0]                port_a, port_b;

   bu_wb_addr_gen #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_addr_gen (
      .len_i   (len_q),
      .g_i     (g_q),
      .bank_a_o(bank_a),
      .addr_a_o(gen_addr_a),
      .port_a_o(port_a),
      .bank_b_o(bank_b),
      .addr_b_o(gen_addr_b),
      .port_b_o(port_b)
   );

   assign beat = (state_q == ST_RUN) && valid_i;

   // DONE behaves like IDLE for start_i so back-to-back layers lose no cycle.
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      len_d   = len_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start_i) begin
               if (len_is_legal(len_i)) begin
                  state_d = ST_RUN;
                  len_d   = len_i;
                  g_d     = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (valid_i) begin
               if (g_q == 4'(BEATS_PER_LAYER - 1)) begin
                  state_d = ST_DRAIN;
                  g_d     = '0;
               end else begin
                  g_d = g_q + 4'd1;
               end
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Crossbar: every bank port receives exactly one BU output per beat.
   always_comb begin
      we_a_d   = '0;
      we_b_d   = '0;
      addr_a_d = '0;
      addr_b_d = '0;
      din_a_d  = '0;
      din_b_d  = '0;
      if (beat) begin
         for (int b = 0; b < N_BANK; b++) begin
            for (int k = 0; k < N_BU; k++) begin
               if (bank_a[3*k +: 3] == 3'(b)) begin
                  if (port_a[k]) begin
                     we_b_d[b]                            = 1'b1;
                     addr_b_d[ADDR_WIDTH*b +: ADDR_WIDTH] = gen_addr_a[ADDR_WIDTH*k +: ADDR_WIDTH];
                     din_b_d[DATA_WIDTH*b +: DATA_WIDTH]  = bu_a_i[DATA_WIDTH*k +: DATA_WIDTH];
                  end else begin
                     we_a_d[b]                            = 1'b1;
                     addr_a_d[ADDR_WIDTH*b +: ADDR_WIDTH] = gen_addr_a[ADDR_WIDTH*k +: ADDR_WIDTH];
                     din_a_d[DATA_WIDTH*b +: DATA_WIDTH]  = bu_a_i[DATA_WIDTH*k +: DATA_WIDTH];
                  end
               end
               if (bank_b[3*k +: 3] == 3'(b)) begin
                  if (port_b[k]) begin
                     we_b_d[b]                            = 1'b1;
                     addr_b_d[ADDR_WIDTH*b +: ADDR_WIDTH] = gen_addr_b[ADDR_WIDTH*k +: ADDR_WIDTH];
                     din_b_d[DATA_WIDTH*b +: DATA_WIDTH]  = bu_b_i[DATA_WIDTH*k +: DATA_WIDTH];
                  end else begin
                     we_a_d[b]                            = 1'b1;
                     addr_a_d[ADDR_WIDTH*b +: ADDR_WIDTH] = gen_addr_b[ADDR_WIDTH*k +: ADDR_WIDTH];
                     din_a_d[DATA_WIDTH*b +: DATA_WIDTH]  = bu_b_i[DATA_WIDTH*k +: DATA_WIDTH];
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         g_q      <= '0;
         len_q    <= '0;
         err_q    <= 1'b0;
         we_a_q   <= '0;
         we_b_q   <= '0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         din_a_q  <= '0;
         din_b_q  <= '0;
      end else begin
         state_q  <= state_d;
         g_q      <= g_d;
         len_q    <= len_d;
         err_q    <= err_d;
         we_a_q   <= we_a_d;
         we_b_q   <= we_b_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         din_a_q  <= din_a_d;
         din_b_q  <= din_b_d;
      end
   end

   assign we_a_o   = we_a_q;
   assign we_b_o   = we_b_q;
   assign addr_a_o = addr_a_q;
   assign addr_b_o = addr_b_q;
   assign din_a_o  = din_a_q;
   assign din_b_o  = din_b_q;
   assign busy_o   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done_o   = (state_q == ST_DONE);
   assign err_o    = err_q;
endmodule

// File: tb/tb_bu_writeback.sv
// tb/tb_bu_writeback.sv - randomized self-checking bench for bu_writeback against a coefficient-index model
module tb_bu_writeback;
   localparam int DW = 12;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_i, start_i, valid_i;
   logic [7:0]    len_i;
   logic [8*DW-1:0] bu_a_i, bu_b_i;
   logic [7:0]    we_a_o, we_b_o;
   logic [8*AW-1:0] addr_a_o, addr_b_o;
   logic [8*DW-1:0] din_a_o, din_b_o;
   logic          busy_o, done_o, err_o;

   bu_writeback dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .start_i (start_i),
      .len_i   (len_i),
      .valid_i (valid_i),
      .bu_a_i  (bu_a_i),
      .bu_b_i  (bu_b_i),
      .we_a_o  (we_a_o),
      .we_b_o  (we_b_o),
      .addr_a_o(addr_a_o),
      .addr_b_o(addr_b_o),
      .din_a_o (din_a_o),
      .din_b_o (din_b_o),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .err_o   (err_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0]   a_v [8];
   logic [DW-1:0]   b_v [8];
   logic [7:0]      e_we_a, e_we_b;
   logic [8*AW-1:0] e_addr_a, e_addr_b;
   logic [8*DW-1:0] e_din_a, e_din_b;
   logic            e_busy, e_done, e_err;
   int              wr_cnt [256];
   int              wr_total;
   int              lens [7] = '{2, 4, 8, 16, 32, 64, 128};

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_exp();
      e_we_a = '0; e_we_b = '0;
      e_addr_a = '0; e_addr_b = '0;
      e_din_a = '0; e_din_b = '0;
   endtask

   task automatic set_data(input bit v);
      for (int k = 0; k < 8; k++) begin
         bu_a_i[k*DW +: DW] = a_v[k];
         bu_b_i[k*DW +: DW] = b_v[k];
      end
      valid_i = v;
   endtask

   task automatic drive_data(input bit v);
      for (int k = 0; k < 8; k++) begin
         a_v[k] = DW'($urandom);
         b_v[k] = DW'($urandom);
      end
      set_data(v);
   endtask

   // Coefficient c lives in bank c%8, row c/8; short layers use the row parity for the port.
   task automatic place(input int c, input logic [DW-1:0] v, input bit upper, input int len);
      int  bank = c % 8;
      int  row  = c / 8;
      bit  pb   = (len >= 8) ? !upper : ((row % 2) == 1);
      if (!pb) begin
         e_we_a[bank] = 1'b1;
         e_addr_a[bank*AW +: AW] = AW'(row);
         e_din_a[bank*DW +: DW] = v;
      end else begin
         e_we_b[bank] = 1'b1;
         e_addr_b[bank*AW +: AW] = AW'(row);
         e_din_b[bank*DW +: DW] = v;
      end
   endtask

   task automatic model_beat(input int len, input int g);
      clear_exp();
      for (int k = 0; k < 8; k++) begin
         int t = 8*g + k;
         int i = (t / len) * 2 * len + (t % len);
         place(i, a_v[k], 1'b1, len);
         place(i + len, b_v[k], 1'b0, len);
      end
   endtask

   task automatic check_now(input string tag);
      chk({tag, ".we_a"}, we_a_o, e_we_a);
      chk({tag, ".we_b"}, we_b_o, e_we_b);
      chk({tag, ".addr_a"}, addr_a_o, e_addr_a);
      chk({tag, ".addr_b"}, addr_b_o, e_addr_b);
      chk({tag, ".din_a"}, din_a_o, e_din_a);
      chk({tag, ".din_b"}, din_b_o, e_din_b);
      chk({tag, ".busy"}, busy_o, e_busy);
      chk({tag, ".done"}, done_o, e_done);
      chk({tag, ".err"}, err_o, e_err);
      for (int b = 0; b < 8; b++) begin
         if (we_a_o[b]) begin
            wr_cnt[int'(addr_a_o[b*AW +: AW])*8 + b]++;
            wr_total++;
         end
         if (we_b_o[b]) begin
            wr_cnt[int'(addr_b_o[b*AW +: AW])*8 + b]++;
            wr_total++;
         end
      end
   endtask

   task automatic tick_check(input string tag);
      @(posedge clk);
      #1;
      check_now(tag);
   endtask

   task automatic do_start(input int len, input bit legal);
      foreach (wr_cnt[c]) wr_cnt[c] = 0;
      wr_total = 0;
      start_i  = 1'b1;
      len_i    = 8'(len);
      drive_data(1'($urandom_range(0, 1)));
      clear_exp();
      e_busy = legal; e_done = 1'b0; e_err = !legal;
      tick_check("start");
      start_i = 1'b0;
   endtask

   task automatic do_beats(input int len, input int gap, input int g_from, input int g_to);
      for (int g = g_from; g <= g_to; g++) begin
         drive_data(1'b1);
         model_beat(len, g);
         e_busy = 1'b1; e_done = 1'b0; e_err = 1'b0;
         tick_check("beat");
         if (g != g_to) begin
            for (int n = 0; n < gap; n++) begin
               start_i = 1'($urandom_range(0, 1));
               len_i   = 8'(lens[$urandom_range(0, 6)]);
               drive_data(1'b0);
               clear_exp();
               tick_check("gap");
               start_i = 1'b0;
            end
         end
      end
   endtask

   task automatic finish_layer(input int chain_len);
      int bad = 0;
      start_i = 1'($urandom_range(0, 1));
      len_i   = 8'(lens[$urandom_range(0, 6)]);
      drive_data(1'b1);
      clear_exp();
      e_busy = 1'b0; e_done = 1'b1; e_err = 1'b0;
      tick_check("done");
      start_i = 1'b0;
      chk("wr_total", wr_total, 256);
      for (int c = 0; c < 256; c++) if (wr_cnt[c] != 1) bad++;
      chk("wr_once", bad, 0);
      if (chain_len != 0) begin
         do_start(chain_len, 1'b1);
      end else begin
         drive_data(1'b0);
         e_done = 1'b0;
         tick_check("idle");
      end
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; valid_i = 1'b0; len_i = '0;
      bu_a_i = '0; bu_b_i = '0;
      clear_exp();
      e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      wr_total = 0;
      foreach (wr_cnt[c]) wr_cnt[c] = 0;
      repeat (3) @(posedge clk);
      #1;
      check_now("in_rst");
      rst_i = 1'b0;
      tick_check("reset");

      // len=128, first beat with fixed data
      do_start(128, 1'b1);
      for (int k = 0; k < 8; k++) begin
         a_v[k] = DW'(k + 1);
         b_v[k] = DW'(k + 'h100);
      end
      set_data(1'b1);
      model_beat(128, 0);
      tick_check("l128");
      chk("l128.we_all", {we_a_o, we_b_o}, 16'hffff);
      chk("l128.addr_a0", addr_a_o, 40'd0);
      chk("l128.addr_b16", addr_b_o, {8{5'd16}});
      chk("l128.din_a3", din_a_o[3*DW +: DW], 12'd4);
      chk("l128.din_b5", din_b_o[5*DW +: DW], 12'h105);
      do_beats(128, 0, 1, 15);
      finish_layer(0);

      // len=2, first beat, then chained straight into a len=4 layer
      do_start(2, 1'b1);
      drive_data(1'b1);
      model_beat(2, 0);
      tick_check("l2");
      chk("l2.bank0_a", din_a_o[0 +: DW], a_v[0]);
      chk("l2.bank2_a", din_a_o[2*DW +: DW], b_v[0]);
      chk("l2.bank0_b", din_b_o[0 +: DW], a_v[4]);
      chk("l2.bank0_b_addr", addr_b_o[0 +: AW], 5'd1);
      do_beats(2, 0, 1, 15);
      finish_layer(4);
      do_beats(4, 1, 0, 15);
      finish_layer(0);

      // len=8 with 3-cycle gaps
      do_start(8, 1'b1);
      do_beats(8, 3, 0, 15);
      finish_layer(0);

      // illegal lengths
      foreach (lens[j]) begin
         if (j < 5) begin
            int bad_len;
            case (j)
               0: bad_len = 6;
               1: bad_len = 0;
               2: bad_len = 1;
               3: bad_len = 255;
               default: bad_len = 12;
            endcase
            do_start(bad_len, 1'b0);
            for (int n = 0; n < 3; n++) begin
               drive_data(1'b1);
               clear_exp();
               e_err = 1'b0; e_busy = 1'b0; e_done = 1'b0;
               tick_check("after_err");
            end
         end
      end

      // reset mid-layer after beat 7 of len=32
      do_start(32, 1'b1);
      do_beats(32, 0, 0, 7);
      drive_data(1'b1);
      #2;
      rst_i = 1'b1;
      #1;
      clear_exp();
      e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      check_now("async_rst");
      tick_check("rst_hold");
      rst_i = 1'b0;
      for (int n = 0; n < 4; n++) begin
         drive_data(1'b1);
         tick_check("post_rst");
      end
      do_start(32, 1'b1);
      do_beats(32, 0, 0, 15);
      finish_layer(0);

      // random legal layers, some chained
      for (int r = 0; r < 6; r++) begin
         int len = lens[$urandom_range(0, 6)];
         int nxt = lens[$urandom_range(0, 6)];
         do_start(len, 1'b1);
         do_beats(len, $urandom_range(0, 2), 0, 15);
         finish_layer(nxt);
         do_beats(nxt, $urandom_range(0, 2), 0, 15);
         finish_layer(0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
